// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register pair with a 32-cycle restoring divider.
// Define HILO_BYPASS_EN to forward direct HI/LO writes to the read ports combinationally.
module hilo_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] hi_wdata,
    input  logic [31:0] lo_wdata,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic        busy,
    output logic        div_done,
    output logic        div_by_zero
);
    typedef enum logic {IDLE, DIV} state_t;
    state_t state, state_nx;
    logic [31:0] hi, lo, q, r, d, q_nx, r_nx, a_mag, b_mag;
    logic [32:0] sh, diff;
    logic [5:0]  cnt;
    logic        neg_q, neg_r, start_ok, last;

    always_comb begin
        a_mag    = (div_signed && dividend[31]) ? -dividend : dividend;
        b_mag    = (div_signed && divisor[31]) ? -divisor : divisor;
        sh       = {r, q[31]};
        diff     = sh - {1'b0, d};
        q_nx     = {q[30:0], ~diff[32]};
        r_nx     = diff[32] ? sh[31:0] : diff[31:0];
        start_ok = (state == IDLE) && div_start && !flush;
        last     = cnt == 6'd31;
        state_nx = state;
        if (state == IDLE)
            state_nx = (start_ok && divisor != 32'd0) ? DIV : IDLE;
        else
            state_nx = (flush || last) ? IDLE : DIV;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
            if (state == IDLE) begin
                if (hi_write) hi <= hi_wdata;
                if (lo_write) lo <= lo_wdata;
                if (start_ok && divisor == 32'd0) begin
                    div_done    <= 1'b1;
                    div_by_zero <= 1'b1;
                end else if (start_ok) begin
                    q     <= a_mag;
                    r     <= '0;
                    d     <= b_mag;
                    cnt   <= '0;
                    neg_q <= div_signed && (dividend[31] ^ divisor[31]);
                    neg_r <= div_signed && dividend[31];
                end
            end else if (!flush) begin
                q   <= q_nx;
                r   <= r_nx;
                cnt <= cnt + 6'd1;
                if (last) begin
                    lo       <= neg_q ? -q_nx : q_nx;
                    hi       <= neg_r ? -r_nx : r_nx;
                    div_done <= 1'b1;
                end
            end
        end
    end

    assign busy = state == DIV;
`ifdef HILO_BYPASS_EN
    // Same-cycle forwarding so mfhi/mflo behind mthi/mtlo need no stall; masked during reset.
    assign hi_rdata = (rst_n && state == IDLE && hi_write) ? hi_wdata : hi;
    assign lo_rdata = (rst_n && state == IDLE && lo_write) ? lo_wdata : lo;
`else
    assign hi_rdata = hi;
    assign lo_rdata = lo;
`endif
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: scoreboard bench for hilo_div_unit against an arithmetic reference model.
module tb_hilo_div_unit;
    logic        clk = 0, rst_n = 0;
    logic        hi_write = 0, lo_write = 0, div_start = 0, div_signed = 0, flush = 0;
    logic [31:0] hi_wdata = 0, lo_wdata = 0, dividend = 0, divisor = 0;
    logic [31:0] hi_rdata, lo_rdata;
    logic        busy, div_done, div_by_zero;
    logic [64:0] sb[$];
    logic [31:0] m_hi = 0, m_lo = 0;
    int          n_cmp = 0, n_bad = 0;

    hilo_div_unit dut (
        .clk(clk), .rst_n(rst_n), .hi_write(hi_write), .lo_write(lo_write),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .div_start(div_start),
        .div_signed(div_signed), .dividend(dividend), .divisor(divisor), .flush(flush),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .busy(busy), .div_done(div_done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && div_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("dbz", {31'd0, div_by_zero}, {31'd0, e[64]});
                chk("hi", hi_rdata, e[63:32]);
                chk("lo", lo_rdata, e[31:0]);
            end
        end
    end

    task automatic do_write(bit he, logic [31:0] h, bit le, logic [31:0] l);
        hi_write = he; hi_wdata = h; lo_write = le; lo_wdata = l;
        #1;
`ifdef HILO_BYPASS_EN
        chk("byp_hi", hi_rdata, he ? h : m_hi);
        chk("byp_lo", lo_rdata, le ? l : m_lo);
`else
        chk("pre_hi", hi_rdata, m_hi);
        chk("pre_lo", lo_rdata, m_lo);
`endif
        @(posedge clk); #1;
        hi_write = 0; lo_write = 0;
        if (he) m_hi = h;
        if (le) m_lo = l;
        chk("wr_hi", hi_rdata, m_hi);
        chk("wr_lo", lo_rdata, m_lo);
    endtask

    task automatic do_div(bit sgn, logic [31:0] a, logic [31:0] b, bit wr_same, bit wr_during);
        longint sa, sb_, qq, rr;
        int n;
        if (wr_same) begin
            hi_write = 1; hi_wdata = $urandom; m_hi = hi_wdata;
        end
        if (b == 0) sb.push_back({1'b1, m_hi, m_lo});
        else begin
            sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
            sb_ = sgn ? {{32{b[31]}}, b} : {32'd0, b};
            qq = sa / sb_;
            rr = sa % sb_;
            m_lo = qq[31:0];
            m_hi = rr[31:0];
            sb.push_back({1'b0, m_hi, m_lo});
        end
        div_start = 1; div_signed = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        div_start = 0; hi_write = 0;
        if (b == 0) chk("dbz_busy", {31'd0, busy}, 32'd0);
        else begin
            n = 0;
            while (busy && n < 100) begin
                if (wr_during) begin
                    hi_write = 1; lo_write = 1; hi_wdata = $urandom; lo_wdata = $urandom;
                    div_start = 1; divisor = 0;
                end
                @(posedge clk); #1;
                n++;
            end
            hi_write = 0; lo_write = 0; div_start = 0;
            chk("busy_cycles", n, 32);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        #3;
        chk("rst_hi", hi_rdata, 0);
        chk("rst_lo", lo_rdata, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {30'd0, div_done, div_by_zero}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        do_div(0, 100, 7, 0, 0);
        do_div(1, -32'sd7, 2, 0, 0);
        chk("neg7_lo", m_lo, 32'hFFFFFFFD);
        do_div(1, 7, -32'sd2, 0, 0);
        chk("neg2_hi", m_hi, 32'd1);
        do_div(1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        do_write(1, 32'h1234, 0, 0);
        do_div(0, 55, 0, 0, 0);
        do_write(1, 32'h55, 1, 32'h66);
        // flush mid-divide; writes during DIV must be ignored
        div_start = 1; div_signed = 0; dividend = 1000; divisor = 3;
        @(posedge clk); #1;
        div_start = 0;
        repeat (10) begin
            hi_write = 1; hi_wdata = 32'hAA;
            @(posedge clk); #1;
        end
        hi_write = 0; flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_busy", {31'd0, busy}, 0);
        chk("flush_hi", hi_rdata, m_hi);
        chk("flush_lo", lo_rdata, m_lo);
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_nodone", {31'd0, div_done}, 0);
        end
        // flush in IDLE blocks start but not writes
        flush = 1; div_start = 1; divisor = 3; hi_write = 1; hi_wdata = 32'hBEEF;
        @(posedge clk); #1;
        flush = 0; div_start = 0; hi_write = 0; m_hi = 32'hBEEF;
        chk("iflush_busy", {31'd0, busy}, 0);
        chk("iflush_hi", hi_rdata, m_hi);
        // reset in the middle of a divide
        div_start = 1; dividend = $urandom; divisor = 5;
        @(posedge clk); #1;
        div_start = 0;
        repeat (20) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mrst_hi", hi_rdata, 0);
        chk("mrst_lo", lo_rdata, 0);
        chk("mrst_flags", {29'd0, busy, div_done, div_by_zero}, 0);
        m_hi = 0; m_lo = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        do_div(0, 9, 3, 0, 0);
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 20);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) do_write($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
            do_div($urandom_range(0, 1), a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
